dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 107 ++++++++++
 tb/tb_dcache_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache with 256-bit lines. Hits complete the same cycle.
// A miss stalls the CPU through optional writeback plus fetch. Memory handshakes by holding req until a one-cycle ack.
module dcache_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int INDEX_W   = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int TAG_W = 32 - 5 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [7:0]         word_off;
  logic               hit, store_hit, fill;
  logic               unused_addr_lsb;

  assign index           = cpu_addr_i[5+INDEX_W-1:5];
  assign tag             = cpu_addr_i[31:5+INDEX_W];
  assign word_off        = {cpu_addr_i[4:2], 5'b0};
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign hit       = cpu_req_i & valid_q[index] & (tag_q[index] == tag);
  assign store_hit = (state_q == IDLE) & hit & cpu_we_i;
  assign fill      = (state_q == ALLOCATE) & mem_ack_i;

  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          cpu_rdata_o = data_q[index][word_off +: 32];
        end else if (cpu_req_i) begin
          cpu_stall_o = 1'b1;
          state_d     = (valid_q[index] & dirty_q[index]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        // Address and data come from the victim line; the held CPU address picks the index.
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[index], index, 5'b0};
        mem_wdata_o = data_q[index];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {tag, index, 5'b0};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (store_hit) dirty_q[index] <= 1'b1;
      if (fill) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end
    end
  end

  // Tag and data contents need no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (store_hit) data_q[index][word_off +: 32] <= cpu_wdata_i;
    if (fill) begin
      data_q[index] <= mem_rdata_i;
      tag_q[index]  <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed table of per-cycle vectors for dcache_ctrl, plus a hand-written slow-fetch sequence.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, req, we, ack;
    logic [31:0] addr, wdata, rbase;
    logic        e_stall, e_mreq, e_mwe;
    logic [31:0] e_maddr;
    logic        chk_rd;
    logic [31:0] e_rdata;
    logic        chk_wd;
    logic [31:0] e_wd1;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic vec_t mk(input logic r, input logic q, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic k, input logic [31:0] rb,
                              input logic es, input logic em, input logic ew, input logic [31:0] ea,
                              input logic cr, input logic [31:0] er, input logic cw, input logic [31:0] ewd);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = wd; v.ack = k; v.rbase = rb;
    v.e_stall = es; v.e_mreq = em; v.e_mwe = ew; v.e_maddr = ea;
    v.chk_rd = cr; v.e_rdata = er; v.chk_wd = cw; v.e_wd1 = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic q, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic k, input logic [31:0] rb);
    rst = r; cpu_req = q; cpu_we = w; cpu_addr = a; cpu_wdata = wd; mem_ack = k;
    mem_rdata = line_of(rb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst req we addr wdata ack rbase | stall mreq mwe maddr chk_rd rdata chk_wd wd1
    tbl.push_back(mk(1,0,0,32'h0,  0,0,0,      0,0,0,32'h0,  1,32'h0,0,0));
    tbl.push_back(mk(1,0,0,32'h0,  0,0,0,      0,0,0,32'h0,  1,32'h0,0,0));
    tbl.push_back(mk(0,1,0,32'h40, 0,0,0,      1,0,0,32'h0,  0,0,0,0));           // cold miss
    tbl.push_back(mk(0,1,0,32'h40, 0,0,0,      1,1,0,32'h40, 0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h40, 0,1,0,      1,1,0,32'h40, 0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h40, 0,0,0,      0,0,0,32'h0,  1,32'h0,0,0));       // retry hits
    tbl.push_back(mk(0,1,0,32'h4C, 0,0,0,      0,0,0,32'h0,  1,32'h3,0,0));
    tbl.push_back(mk(0,1,1,32'h44, 32'hDEADBEEF,0,0, 0,0,0,32'h0, 0,0,0,0));     // store hit
    tbl.push_back(mk(0,1,0,32'h44, 0,0,0,      0,0,0,32'h0,  1,32'hDEADBEEF,0,0));
    tbl.push_back(mk(0,0,0,32'h44, 0,1,32'h500,0,0,0,32'h0,  1,32'h0,0,0));       // stray ack
    tbl.push_back(mk(0,1,0,32'h44, 0,0,0,      0,0,0,32'h0,  1,32'hDEADBEEF,0,0));
    tbl.push_back(mk(0,1,0,32'h240,0,0,0,      1,0,0,32'h0,  0,0,0,0));           // dirty conflict
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,0,32'h240,0,0,0,    1,1,1,32'h40, 0,0,1,32'hDEADBEEF));
    tbl.push_back(mk(0,1,0,32'h240,0,1,0,      1,1,1,32'h40, 0,0,1,32'hDEADBEEF));
    tbl.push_back(mk(0,1,0,32'h240,0,0,32'h100,1,1,0,32'h240,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h240,0,1,32'h100,1,1,0,32'h240,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h240,0,0,0,      0,0,0,32'h0,  1,32'h100,0,0));
    tbl.push_back(mk(0,1,0,32'h25C,0,0,0,      0,0,0,32'h0,  1,32'h107,0,0));
    tbl.push_back(mk(0,1,0,32'h40, 0,0,0,      1,0,0,32'h0,  0,0,0,0));           // clean victim
    tbl.push_back(mk(0,1,0,32'h40, 0,1,32'h200,1,1,0,32'h40, 0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h44, 0,0,0,      0,0,0,32'h0,  1,32'h201,0,0));
    tbl.push_back(mk(0,1,1,32'h60, 32'h11223344,0,0, 1,0,0,32'h0, 0,0,0,0));     // store miss
    tbl.push_back(mk(0,1,1,32'h60, 32'h11223344,1,32'h300, 1,1,0,32'h60, 0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h60, 32'h11223344,0,0, 0,0,0,32'h0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h60, 0,0,0,      0,0,0,32'h0,  1,32'h11223344,0,0));
    tbl.push_back(mk(0,1,0,32'h260,0,0,0,      1,0,0,32'h0,  0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h260,0,1,0,      1,1,1,32'h60, 0,0,1,32'h301));
    tbl.push_back(mk(1,1,0,32'h260,0,0,0,      1,1,0,32'h260,0,0,0,0));           // reset in ALLOCATE
    tbl.push_back(mk(0,0,0,32'h260,0,0,0,      0,0,0,32'h0,  1,32'h0,0,0));
    tbl.push_back(mk(0,1,0,32'h60, 0,0,0,      1,0,0,32'h0,  0,0,0,0));           // misses again
    tbl.push_back(mk(0,1,0,32'h60, 0,1,32'h400,1,1,0,32'h60, 0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h64, 0,0,0,      0,0,0,32'h0,  1,32'h401,0,0));

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].rbase);
      @(negedge clk);
      chk($sformatf("row%0d stall", i), 32'(cpu_stall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(tbl[i].e_mreq));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].e_mwe));
      chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
      if (tbl[i].chk_rd) chk($sformatf("row%0d rdata", i), cpu_rdata, tbl[i].e_rdata);
      if (tbl[i].chk_wd) chk($sformatf("row%0d wdata_w1", i), mem_wdata[63:32], tbl[i].e_wd1);
      @(posedge clk); #1;
    end

    // Slow fetch: outputs must hold across five ack-less cycles.
    drive(0, 1, 0, 32'h84, 0, 0, 0);
    @(negedge clk);
    chk("slow miss stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("slow%0d stall", i), 32'(cpu_stall), 32'd1);
      chk($sformatf("slow%0d mem_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("slow%0d mem_we", i), 32'(mem_we), 32'd0);
      chk($sformatf("slow%0d mem_addr", i), mem_addr, 32'h80);
      @(posedge clk); #1;
    end
    drive(0, 1, 0, 32'h84, 0, 1, 32'h700);
    @(negedge clk);
    chk("slow ack stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h84, 0, 0, 0);
    @(negedge clk);
    chk("slow hit stall", 32'(cpu_stall), 32'd0);
    chk("slow hit rdata", cpu_rdata, 32'h701);
    chk("slow hit mem_req", 32'(mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
